// File: rtl/branch_pkg.sv
// Shared encodings for the EX-stage branch resolver: op codes, 2-bit counter
// states and the counter update rule used by the history table.
package branch_pkg;

  localparam logic [2:0] NB  = 3'b000;
  localparam logic [2:0] BR  = 3'b001;
  localparam logic [2:0] BMI = 3'b010;
  localparam logic [2:0] BPL = 3'b011;
  localparam logic [2:0] BZ  = 3'b100;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic [1:0] {
    UPD_INC = 2'd0,
    UPD_DEC = 2'd1,
    UPD_SET = 2'd2
  } bht_upd_e;

  // Saturating counter step; an unconditional branch pins the entry to strongly taken.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input bht_upd_e upd);
    case (upd)
      UPD_INC: return (ctr == ST)  ? ST  : ctr + 2'd1;
      UPD_DEC: return (ctr == SNT) ? SNT : ctr - 2'd1;
      UPD_SET: return ST;
      default: return ctr;
    endcase
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Table of 2-bit saturating counters: one combinational read port for fetch,
// one synchronous update port for EX.
module bht_2bit
  import branch_pkg::*;
#(
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CTR_INIT = WNT,
  parameter int         IDXW     = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IDXW-1:0] i_rd_idx,
  output logic            o_rd_taken,
  input  logic            i_wr_en,
  input  logic [IDXW-1:0] i_wr_idx,
  input  bht_upd_e        i_wr_upd
);

  logic [1:0] r_ctr [ENTRIES];

  // Read sees the stored value, so a same-cycle write to this entry is not bypassed.
  assign o_rd_taken = r_ctr[i_rd_idx][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= CTR_INIT;
      end
    end else if (i_wr_en) begin
      r_ctr[i_wr_idx] <= ctr_next(r_ctr[i_wr_idx], i_wr_upd);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: signed condition evaluation, target adder,
// registered redirect/flush, predictor training and branch statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 16,
  parameter logic [1:0] CTR_INIT    = WNT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_pred_taken,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_pc_plus_4,
  input  logic [XLEN-1:0] ex_a,
  input  logic [XLEN-1:0] ex_b,
  input  logic [2:0]      ex_branch,
  input  logic            ex_pred_taken,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            illegal_op,
  output logic [31:0]     br_count,
  output logic [31:0]     mispredict_count
);

  localparam int IDXW = $clog2(BHT_ENTRIES);

  logic            r_flush;
  logic            r_illegal;
  logic [XLEN-1:0] r_redirectPc;
  logic [31:0]     r_brCount;
  logic [31:0]     r_mispCount;

  logic            w_accept;
  logic            w_lt;
  logic            w_eq;
  logic            w_gt;
  logic            w_isLegal;
  logic            w_isBranch;
  logic            w_taken;
  logic            w_mispredict;
  logic [XLEN-1:0] w_target;
  bht_upd_e        w_upd;
  logic            w_unusedPcBits;

  // An op in EX while a flush is out is on the wrong path and must be ignored.
  assign w_accept   = ex_valid && !r_flush;
  assign w_lt       = ex_a[XLEN-1];
  assign w_eq       = (ex_a == '0);
  assign w_gt       = !w_lt && !w_eq;
  assign w_isLegal  = (ex_branch <= BZ);
  assign w_isBranch = w_isLegal && (ex_branch != NB);
  assign w_target   = ex_pc_plus_4 + ex_b;

  always_comb begin
    w_taken = 1'b0;
    case (ex_branch)
      BR:      w_taken = 1'b1;
      BMI:     w_taken = w_lt;
      BPL:     w_taken = w_gt;
      BZ:      w_taken = w_eq;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_upd = UPD_DEC;
    if (ex_branch == BR) begin
      w_upd = UPD_SET;
    end else if (w_taken) begin
      w_upd = UPD_INC;
    end
  end

  // NB and illegal ops are never taken, so a taken prediction on them also redirects.
  assign w_mispredict = w_accept && (w_taken != ex_pred_taken);

  bht_2bit #(
    .ENTRIES  (BHT_ENTRIES),
    .CTR_INIT (CTR_INIT),
    .IDXW     (IDXW)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (f_pc[IDXW+1:2]),
    .o_rd_taken (f_pred_taken),
    .i_wr_en    (w_accept && w_isBranch),
    .i_wr_idx   (ex_pc[IDXW+1:2]),
    .i_wr_upd   (w_upd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush      <= 1'b0;
      r_illegal    <= 1'b0;
      r_redirectPc <= '0;
      r_brCount    <= '0;
      r_mispCount  <= '0;
    end else begin
      r_flush   <= w_mispredict;
      r_illegal <= w_accept && !w_isLegal;
      if (w_mispredict) begin
        r_redirectPc <= w_taken ? w_target : ex_pc_plus_4;
        r_mispCount  <= r_mispCount + 32'd1;
      end
      if (w_accept && w_isBranch) begin
        r_brCount <= r_brCount + 32'd1;
      end
    end
  end

  assign redirect_valid   = r_flush;
  assign flush            = r_flush;
  assign redirect_pc      = r_redirectPc;
  assign illegal_op       = r_illegal;
  assign br_count         = r_brCount;
  assign mispredict_count = r_mispCount;

  assign w_unusedPcBits = ^{f_pc[XLEN-1:IDXW+2], f_pc[1:0], ex_pc[XLEN-1:IDXW+2], ex_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a behavioural model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  localparam int         XLEN    = 32;
  localparam int         ENTRIES = 16;
  localparam logic [1:0] INIT    = 2'b01;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] f_pc;
  logic            f_pred_taken;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_pc_plus_4;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [2:0]      ex_branch;
  logic            ex_pred_taken;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            illegal_op;
  logic [31:0]     br_count;
  logic [31:0]     mispredict_count;

  branch_resolve_unit #(
    .XLEN        (XLEN),
    .BHT_ENTRIES (ENTRIES),
    .CTR_INIT    (INIT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .f_pc             (f_pc),
    .f_pred_taken     (f_pred_taken),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_pc_plus_4     (ex_pc_plus_4),
    .ex_a             (ex_a),
    .ex_b             (ex_b),
    .ex_branch        (ex_branch),
    .ex_pred_taken    (ex_pred_taken),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .illegal_op       (illegal_op),
    .br_count         (br_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nVectors = 0;
  int nMiscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc >> 2) & 32'(ENTRIES - 1));
  endfunction

  // Behavioural model: counters as plain integers, outputs as expected values.
  int          mctr [ENTRIES];
  bit          modelReady = 1'b0;
  logic        expRv;
  logic        expIll;
  logic [31:0] expPc;
  logic [31:0] expBr;
  logic [31:0] expMp;

  always @(posedge clk) begin : model
    logic signed [31:0] sa;
    logic [31:0]        target;
    bit                 acc;
    bit                 tk;
    bit                 legal;
    bit                 newRv;
    int                 i;
    if (rst) begin
      for (int k = 0; k < ENTRIES; k++) mctr[k] = int'(INIT);
      expRv = 1'b0;
      expIll = 1'b0;
      expPc = '0;
      expBr = '0;
      expMp = '0;
      modelReady = 1'b1;
    end else begin
      acc    = ex_valid && !expRv;
      legal  = (ex_branch <= 3'd4);
      sa     = $signed(ex_a);
      target = ex_pc_plus_4 + ex_b;
      case (ex_branch)
        3'd1:    tk = 1'b1;
        3'd2:    tk = (sa < 0);
        3'd3:    tk = (sa > 0);
        3'd4:    tk = (sa == 0);
        default: tk = 1'b0;
      endcase
      newRv  = acc && (tk != ex_pred_taken);
      expIll = acc && !legal;
      if (newRv) begin
        expPc = tk ? target : ex_pc_plus_4;
        expMp = expMp + 1;
      end
      expRv = newRv;
      if (acc && legal && ex_branch != 3'd0) begin
        expBr = expBr + 1;
        i = idxOf(ex_pc);
        if (ex_branch == 3'd1) mctr[i] = 3;
        else if (tk) mctr[i] = (mctr[i] == 3) ? 3 : mctr[i] + 1;
        else mctr[i] = (mctr[i] == 0) ? 0 : mctr[i] - 1;
      end
    end
  end

  // Compare every cycle, mid low phase: registered outputs settled, f_pc stable.
  always begin
    @(negedge clk);
    #2;
    if (modelReady) begin
      checkOutput("redirect_valid", 32'(redirect_valid), 32'(expRv));
      checkOutput("flush", 32'(flush), 32'(expRv));
      checkOutput("illegal_op", 32'(illegal_op), 32'(expIll));
      checkOutput("br_count", br_count, expBr);
      checkOutput("mispredict_count", mispredict_count, expMp);
      checkOutput("f_pred_taken", 32'(f_pred_taken), 32'(mctr[idxOf(f_pc)] >= 2));
      if (expRv) checkOutput("redirect_pc", redirect_pc, expPc);
    end
  end

  task automatic applyStimulus(input logic v, input logic [2:0] br, input logic [31:0] pc,
                               input logic [31:0] pc4, input logic [31:0] a, input logic [31:0] b,
                               input logic pred, input logic [31:0] fpc);
    @(negedge clk);
    ex_valid      = v;
    ex_branch     = br;
    ex_pc         = pc;
    ex_pc_plus_4  = pc4;
    ex_a          = a;
    ex_b          = b;
    ex_pred_taken = pred;
    f_pc          = fpc;
  endtask

  task automatic idleCycle(input logic [31:0] fpc);
    applyStimulus(1'b0, NB, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, fpc);
  endtask

  task automatic pulseReset();
    idleCycle(32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_branch = NB; ex_pc = '0; ex_pc_plus_4 = '0;
    ex_a = '0; ex_b = '0; ex_pred_taken = 1'b0; f_pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #3 checkOutput("reset_fpred", 32'(f_pred_taken), 32'h0);
    idleCycle(32'h0);
    #3;
    checkOutput("reset_br_count", br_count, 32'h0);
    checkOutput("reset_misp_count", mispredict_count, 32'h0);
    checkOutput("reset_redirect", 32'(redirect_valid), 32'h0);

    // Signed BMI taken, then BPL with the same negative operand.
    applyStimulus(1'b1, BMI, 32'h110, 32'h104, 32'hFFFF_FFFF, 32'h20, 1'b0, 32'h110);
    idleCycle(32'h110);
    #3;
    checkOutput("bmi_redirect_pc", redirect_pc, 32'h124);
    checkOutput("bmi_flush", 32'(flush), 32'h1);
    checkOutput("bmi_misp_count", mispredict_count, 32'h1);
    checkOutput("bmi_fpred", 32'(f_pred_taken), 32'h1);
    applyStimulus(1'b1, BPL, 32'h110, 32'h104, 32'hFFFF_FFFF, 32'h20, 1'b0, 32'h110);
    idleCycle(32'h110);
    #3;
    checkOutput("bpl_no_redirect", 32'(redirect_valid), 32'h0);
    checkOutput("bpl_misp_count", mispredict_count, 32'h1);
    checkOutput("bpl_br_count", br_count, 32'h2);
    checkOutput("bpl_fpred", 32'(f_pred_taken), 32'h0);

    // Train entry for 0x100 up to strongly taken, then down past zero.
    for (int n = 0; n < 2; n++) begin
      applyStimulus(1'b1, BZ, 32'h100, 32'h104, 32'h0, 32'h8, 1'b0, 32'h100);
      idleCycle(32'h100);
    end
    #3 checkOutput("train_up_fpred", 32'(f_pred_taken), 32'h1);
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1'b1, BZ, 32'h100, 32'h104, 32'h5, 32'h8, 1'b0, 32'h100);
    end
    idleCycle(32'h100);
    #3 checkOutput("train_sat_fpred", 32'(f_pred_taken), 32'h0);
    applyStimulus(1'b1, BZ, 32'h100, 32'h104, 32'h0, 32'h8, 1'b0, 32'h100);
    idleCycle(32'h100);
    #3 checkOutput("train_from_zero_fpred", 32'(f_pred_taken), 32'h0);

    // Squash: second mispredicting op lands while flush is high.
    pulseReset();
    applyStimulus(1'b1, BR, 32'h300, 32'h304, 32'h0, 32'h10, 1'b0, 32'h308);
    applyStimulus(1'b1, BR, 32'h308, 32'h30C, 32'h0, 32'h40, 1'b0, 32'h308);
    #3;
    checkOutput("squash_first_redirect", 32'(redirect_valid), 32'h1);
    checkOutput("squash_first_pc", redirect_pc, 32'h314);
    idleCycle(32'h308);
    #3;
    checkOutput("squash_no_second", 32'(redirect_valid), 32'h0);
    checkOutput("squash_misp_count", mispredict_count, 32'h1);
    checkOutput("squash_br_count", br_count, 32'h1);
    checkOutput("squash_no_train", 32'(f_pred_taken), 32'h0);

    // Target wraparound, then an illegal code predicted taken.
    applyStimulus(1'b1, BR, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h8, 1'b0, 32'h0);
    idleCycle(32'h0);
    #3 checkOutput("wrap_redirect_pc", redirect_pc, 32'h4);
    applyStimulus(1'b1, 3'b110, 32'h500, 32'h504, 32'h0, 32'h40, 1'b1, 32'h0);
    idleCycle(32'h0);
    #3;
    checkOutput("illegal_flag", 32'(illegal_op), 32'h1);
    checkOutput("illegal_redirect_pc", redirect_pc, 32'h504);
    checkOutput("illegal_br_count", br_count, 32'h2);
    checkOutput("illegal_misp_count", mispredict_count, 32'h3);

    // Fetch and EX hit the same entry in the update cycle.
    pulseReset();
    applyStimulus(1'b1, BR, 32'h100, 32'h104, 32'h0, 32'h40, 1'b0, 32'h100);
    #3 checkOutput("collide_old_value", 32'(f_pred_taken), 32'h0);
    idleCycle(32'h100);
    #3;
    checkOutput("collide_new_value", 32'(f_pred_taken), 32'h1);
    checkOutput("collide_redirect_pc", redirect_pc, 32'h144);

    // Reset in the same cycle as a mispredicting accept.
    idleCycle(32'h100);
    applyStimulus(1'b1, BMI, 32'h110, 32'h104, 32'hFFFF_FFFF, 32'h20, 1'b0, 32'h100);
    rst = 1'b1;
    idleCycle(32'h100);
    rst = 1'b0;
    #3;
    checkOutput("midrst_no_redirect", 32'(redirect_valid), 32'h0);
    checkOutput("midrst_misp_count", mispredict_count, 32'h0);
    checkOutput("midrst_br_count", br_count, 32'h0);
    checkOutput("midrst_ctr_init", 32'(f_pred_taken), 32'h0);
    idleCycle(32'h110);
    #3 checkOutput("midrst_no_train", 32'(f_pred_taken), 32'h0);

    idleCycle(32'h0);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, pipelined successor to the combinational branch-condition block. It sits at the EX stage and resolves branch ops with signed condition evaluation. Against the fetch-stage prediction it issues a registered redirect/flush, and it trains a table of 2-bit saturating counters that fetch reads for its next-cycle prediction. It also keeps branch and mispredict statistics.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- BHT_ENTRIES, 16, counter-table depth; power of 2, ≥2
- CTR_INIT, 2'b01, reset value of every counter (weakly not-taken)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- f_pc  in  XLEN  fetch PC, indexes table with f_pc[log2(BHT_ENTRIES)+1:2]
- f_pred_taken  out  1  counter[idx][1], combinational read
- ex_valid  in  1  EX holds a valid op this cycle
- ex_pc  in  XLEN  PC of EX op (table index as for f_pc)
- ex_pc_plus_4  in  XLEN  PC+4 of EX op
- ex_a  in  XLEN  condition operand, two's complement
- ex_b  in  XLEN  branch offset
- ex_branch  in  3  000 NB, 001 BR, 010 BMI, 011 BPL, 100 BZ; 101–111 illegal
- ex_pred_taken  in  1  prediction fetch made for this op
- redirect_valid  out  1  registered, one-cycle pulse
- redirect_pc  out  XLEN  registered, correct next PC
- flush  out  1  registered, equals redirect_valid
- illegal_op  out  1  registered pulse for codes 101–111 with ex_valid
- br_count  out  32  resolved branch ops (BR/BMI/BPL/BZ), wraps
- mispredict_count  out  32  redirects issued, wraps

## Operation
- Accepted op: ex_valid=1 and flush=0 in that cycle. With flush=1, the EX op is wrong-path: no redirect, no table update, no count, no illegal_op.
- Conditions, signed: LT = ex_a[XLEN-1]; EQ = (ex_a==0); GT = !LT && !EQ.
- taken = BR | (BMI&LT) | (BPL&GT) | (BZ&EQ). NB and illegal codes are never taken.
- target = ex_pc_plus_4 + ex_b, truncated mod 2^XLEN (no overflow flag).
- Mispredict: accepted and taken != ex_pred_taken. The next cycle has redirect_valid=flush=1 and redirect_pc = taken ? target : ex_pc_plus_4.
- NB or illegal with ex_pred_taken=1 also mispredicts; redirect_pc = ex_pc_plus_4.
- Table update on accepted op:
  - BMI/BPL/BZ: counter saturating +1 if taken, −1 if not (11 stays 11, 00 stays 00).
  - BR: counter set to 11.
  - NB/illegal: no update.
- br_count increments on accepted BR/BMI/BPL/BZ. mispredict_count increments with each redirect.

## Timing
- Resolution latency 1 cycle: op accepted at edge N gives redirect/flush/illegal_op high for cycle N+1 only.
- Back-to-back accepted ops each resolve, except that an op arriving while flush=1 is squashed.
- Table write takes effect at the edge ending the accept cycle.
- Same-cycle f_pc/ex_pc index collision: f_pred_taken returns the pre-update value (no bypass).
- Reset: all counters to CTR_INIT. redirect_valid, flush, illegal_op, redirect_pc, br_count and mispredict_count go to 0 on the next edge.
- rst overrides an accept in the same cycle: no update and no redirect after reset.

## Structure
- Package branch_pkg:
  - branch op localparams (NB, BR, BMI, BPL, BZ)
  - 2-bit counter state constants (SNT=00, WNT=01, WT=10, ST=11)
- Sub-module bht_2bit:
  - BHT_ENTRIES×2-bit flop array
  - one async read port, one write port (inc/dec/set-strong-taken)
  - sync reset to CTR_INIT
- Top level holds condition logic, target adder, mispredict register and statistics counters.

## Test plan
- Reset, then f_pc=0x0 → f_pred_taken=0. After one idle cycle: br_count=0, mispredict_count=0, redirect_valid=0.
- Signed BMI: ex_branch=010, ex_a=0xFFFFFFFF, ex_pc_plus_4=0x104, ex_b=0x20, ex_pred_taken=0 → next cycle redirect_pc=0x124, flush=1, mispredict_count=1. BPL with same ex_a → not taken, no redirect.
- Training at one PC (0x100):
  - BZ ex_a=0 taken twice → counter 01→10→11, f_pred_taken=1 at f_pc=0x100.
  - Three not-taken BZ → 11→10→01→00, saturating at 00.
- Squash: mispredicting BR at cycle N, another mispredicting op at N+1 (flush=1) → only one redirect, mispredict_count=1, br_count=1.
- Target wrap: ex_pc_plus_4=0xFFFFFFFC, ex_b=0x8, BR, pred=0 → redirect_pc=0x00000004. Illegal code 110 with pred=1 → illegal_op=1 and redirect_pc=ex_pc_plus_4.
- Collision and mid-op reset:
  - f_pc and ex_pc index equal in the update cycle → f_pred_taken reflects the old counter.
  - rst asserted in a mispredict accept cycle → no redirect next cycle, counters at CTR_INIT.
